rd_slot_ctrl: RTL and testbench
===============================

# rd_slot_ctrl

Read-transaction slot controller for the AXI monitor's read path. Allocates one tracking slot per outstanding AR, sequences each slot through address phase and data phase, and frees it on the last R beat. It produces the per-slot state and phase-latency counters that the per-slot read counters consume, and flags timeouts, overflow and unexpected responses.

## Interface
- NumSlots, 4: number of tracking slots (2..16)
- IdWidth, 4: AXI ID width
- CntWidth, 8: width of per-slot latency counters (saturating)
- ArBudget, 16: max cycles from AR allocation to first R beat before timeout
- RBudget, 32: max cycles from first to last R beat before timeout

- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i  in  1  monitored AR valid
- ar_ready_i  in  1  monitored AR ready
- ar_id_i  in  IdWidth  monitored AR ID
- r_valid_i  in  1  monitored R valid
- r_ready_i  in  1  monitored R ready
- r_last_i  in  1  monitored R last
- r_id_i  in  IdWidth  monitored R ID
- slot_state_o  out  NumSlots*2  per-slot state: 0 FREE, 1 AR_PHASE, 2 R_PHASE
- slot_id_o  out  NumSlots*IdWidth  per-slot captured ID
- slot_cnt_o  out  NumSlots*CntWidth  per-slot phase counter
- full_o  out  1  no FREE slot
- overflow_o  out  1  sticky: AR arrived while full
- unexpected_o  out  1  sticky: accepted R beat matched no slot
- timeout_o  out  1  sticky: any slot exceeded its budget
- timeout_slot_o  out  $clog2(NumSlots)  index of first slot that timed out

## Operation
- New AR: ar_valid_i=1 and ar_pending_q=0. ar_pending_q sets on new AR, clears on ar_valid_i&&ar_ready_i. Handshake in the same cycle as a new AR leaves ar_pending_q at 0.
- Allocation: on a new AR with a FREE slot, the lowest-index FREE slot (from registered state) goes to AR_PHASE, captures ar_id_i and resets its counter to 0. When full: no allocation, overflow_o sets.
- Matching on accepted R beat (r_valid_i&&r_ready_i):
  - If a R_PHASE slot has slot_id==r_id_i, that slot matches.
  - Otherwise the AR_PHASE slot with that ID and the largest counter matches (oldest). Ties go to the lowest index.
  - No match: unexpected_o sets and no state changes.
- AR_PHASE -> R_PHASE on a matched beat with r_last_i=0. The counter resets to 0.
- AR_PHASE -> FREE on a matched beat with r_last_i=1 (single-beat burst).
- R_PHASE -> FREE on a matched beat with r_last_i=1.
- Counters: every non-FREE slot increments by 1 per cycle and saturates at 2^CntWidth-1. The counter value in a FREE slot is don't-care, but is driven to 0.
- A slot freed in cycle N is not allocatable until cycle N+1. Allocation and free of different slots in the same cycle are both performed.

## Timing
- All outputs are registered. Any state change is visible on outputs the cycle after the triggering edge.
- Reset: all slots FREE, IDs 0, counters 0, ar_pending_q 0, full_o 0, all sticky flags 0, timeout_slot_o 0.
- Reset asserted mid-transaction drops all slots immediately to FREE. No residual state remains.
- Sticky flags clear only on reset.

## Configuration
- RD_SLOT_CTRL_TIMEOUT_EN defined:
  - timeout_o sets when an AR_PHASE counter reaches ArBudget or an R_PHASE counter reaches RBudget.
  - timeout_slot_o latches the lowest such index on the first timeout and then holds.
  - The slot keeps tracking normally after a timeout.
- Not defined: the budget comparators are removed, and timeout_o and timeout_slot_o are tied to 0.

## Test plan
- Single AR id=3 accepted at cycle 0, single R id=3 last at cycle 5:
  - slot0 is AR_PHASE from cycle 1 with cnt incrementing.
  - slot0 is FREE at cycle 6.
  - All flags stay 0.
- 4-beat burst, id=1, R beats at cycles 4..7 with last at cycle 7:
  - slot0 is AR_PHASE at cycles 1..4 and R_PHASE with cnt restarting at 0 at cycles 5..7.
  - slot0 is FREE at cycle 8.
- Two ARs with id=2 on consecutive cycles, then one single-beat R id=2: slot0 (older) frees and slot1 remains AR_PHASE.
- NumSlots=4: 5 ARs with no R:
  - full_o=1 after the 4th allocation.
  - overflow_o=1 after the 5th AR.
  - A subsequent R last frees a slot, and the next AR allocates it.
- R beat id=7 with no outstanding AR: unexpected_o=1 next cycle and slot states are unchanged.
- With RD_SLOT_CTRL_TIMEOUT_EN and ArBudget=16, AR id=0 with no R: timeout_o=1 and timeout_slot_o=0 once the counter reaches 16. Without the macro, timeout_o stays 0.

Source files
------------

// File: rtl/rd_slot_ctrl.sv
// ----------------------------------------------------------------------------
// rd_slot_ctrl
//
// Read-transaction slot controller for the AXI monitor read path. Each new AR
// takes the lowest-index FREE slot, which then moves through AR_PHASE (waiting
// for the first R beat) and R_PHASE (burst in flight). The slot is released on
// the matching last R beat. Each slot has a saturating phase counter that
// restarts at allocation and again on the AR_PHASE -> R_PHASE step.
//
// Optional feature macro: RD_SLOT_CTRL_TIMEOUT_EN
//   defined     : phase budgets are checked. timeout_o is sticky and
//                 timeout_slot_o latches the lowest offending slot index.
//   not defined : no budget comparators. timeout_o and timeout_slot_o are 0.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   ar_valid_i/ready_i AR handshake being monitored; ar_id_i is the AR ID
//   r_valid_i/ready_i  R handshake being monitored; r_last_i and r_id_i
//   slot_state_o       2 bits per slot: 0 FREE, 1 AR_PHASE, 2 R_PHASE
//   slot_id_o          captured ID per slot
//   slot_cnt_o         phase counter per slot; reads 0 while FREE
//   full_o             no FREE slot left
//   overflow_o         sticky: an AR arrived while full
//   unexpected_o       sticky: an accepted R beat matched no slot
//   timeout_o          sticky: a slot exceeded its phase budget
//   timeout_slot_o     index of the first slot that timed out
// ----------------------------------------------------------------------------
module rd_slot_ctrl #(
    parameter int unsigned NumSlots = 4,
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned CntWidth = 8,
    parameter int unsigned ArBudget = 16,
    parameter int unsigned RBudget  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ar_valid_i,
    input  logic                          ar_ready_i,
    input  logic [IdWidth-1:0]            ar_id_i,
    input  logic                          r_valid_i,
    input  logic                          r_ready_i,
    input  logic                          r_last_i,
    input  logic [IdWidth-1:0]            r_id_i,
    output logic [NumSlots*2-1:0]         slot_state_o,
    output logic [NumSlots*IdWidth-1:0]   slot_id_o,
    output logic [NumSlots*CntWidth-1:0]  slot_cnt_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic                          unexpected_o,
    output logic                          timeout_o,
    output logic [$clog2(NumSlots)-1:0]   timeout_slot_o
);

    localparam int unsigned IdxWidth = $clog2(NumSlots);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_AR   = 2'd1,
        SLOT_R    = 2'd2
    } slot_state_e;

    slot_state_e               state_q [NumSlots];
    slot_state_e               state_d [NumSlots];
    logic [IdWidth-1:0]        id_q    [NumSlots];
    logic [IdWidth-1:0]        id_d    [NumSlots];
    logic [CntWidth-1:0]       cnt_q   [NumSlots];
    logic [CntWidth-1:0]       cnt_d   [NumSlots];

    logic                      ar_pending_q, ar_pending_d;
    logic                      full_q, full_d;
    logic                      overflow_q, overflow_d;
    logic                      unexpected_q, unexpected_d;

    logic                      new_ar_s;
    logic                      free_found_s;
    logic [IdxWidth-1:0]       free_idx_s;
    logic                      r_acc_s;
    logic                      r_hit_s;
    logic [IdxWidth-1:0]       r_idx_s;
    logic                      a_hit_s;
    logic [IdxWidth-1:0]       a_idx_s;
    logic [CntWidth-1:0]       a_cnt_s;
    logic                      match_s;
    logic [IdxWidth-1:0]       match_idx_s;

    // Saturating increment for the phase counters.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == {CntWidth{1'b1}}) ? v : v + CntWidth'(1);
    endfunction

    // Decode of new AR, lowest FREE slot and the slot matched by an accepted R beat.
    always_comb begin
        new_ar_s     = ar_valid_i & ~ar_pending_q;
        r_acc_s      = r_valid_i & r_ready_i;
        free_found_s = 1'b0;
        free_idx_s   = {IdxWidth{1'b0}};
        r_hit_s      = 1'b0;
        r_idx_s      = {IdxWidth{1'b0}};
        a_hit_s      = 1'b0;
        a_idx_s      = {IdxWidth{1'b0}};
        a_cnt_s      = {CntWidth{1'b0}};
        // Descending scans leave the lowest qualifying index in the result.
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            free_found_s = free_found_s | (state_q[i] == SLOT_FREE);
            free_idx_s   = (state_q[i] == SLOT_FREE) ? IdxWidth'(i) : free_idx_s;
            r_hit_s      = r_hit_s | ((state_q[i] == SLOT_R) && (id_q[i] == r_id_i));
            r_idx_s      = ((state_q[i] == SLOT_R) && (id_q[i] == r_id_i)) ? IdxWidth'(i) : r_idx_s;
        end
        // Oldest AR_PHASE slot with this ID; strict '>' keeps the lowest index on ties.
        for (int i = 0; i < int'(NumSlots); i++) begin
            if ((state_q[i] == SLOT_AR) && (id_q[i] == r_id_i) && (!a_hit_s || (cnt_q[i] > a_cnt_s))) begin
                a_hit_s = 1'b1;
                a_idx_s = IdxWidth'(i);
                a_cnt_s = cnt_q[i];
            end else begin
                a_cnt_s = a_cnt_s;
            end
        end
        match_s     = r_acc_s & (r_hit_s | a_hit_s);
        match_idx_s = r_hit_s ? r_idx_s : a_idx_s;
    end

    // Next-state for every slot plus the handshake tracker, full and sticky flags.
    always_comb begin
        ar_pending_d = (ar_valid_i && ar_ready_i) ? 1'b0 : (new_ar_s ? 1'b1 : ar_pending_q);
        overflow_d   = overflow_q | (new_ar_s & ~free_found_s);
        unexpected_d = unexpected_q | (r_acc_s & ~match_s);
        full_d       = 1'b1;
        for (int i = 0; i < int'(NumSlots); i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            cnt_d[i]   = {CntWidth{1'b0}};
            case (state_q[i])
                SLOT_FREE: begin
                    if (new_ar_s && free_found_s && (free_idx_s == IdxWidth'(i))) begin
                        state_d[i] = SLOT_AR;
                        id_d[i]    = ar_id_i;
                    end else begin
                        state_d[i] = SLOT_FREE;
                    end
                end
                SLOT_AR: begin
                    if (match_s && (match_idx_s == IdxWidth'(i))) begin
                        state_d[i] = r_last_i ? SLOT_FREE : SLOT_R;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                SLOT_R: begin
                    if (match_s && (match_idx_s == IdxWidth'(i)) && r_last_i) begin
                        state_d[i] = SLOT_FREE;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = SLOT_FREE;
                end
            endcase
            full_d = full_d & (state_d[i] != SLOT_FREE);
        end
    end

`ifdef RD_SLOT_CTRL_TIMEOUT_EN
    logic                  timeout_q, timeout_d;
    logic [IdxWidth-1:0]   timeout_slot_q, timeout_slot_d;
    logic                  to_hit_s;
    logic [IdxWidth-1:0]   to_idx_s;

    // Budget check on the next-state counters so the flag appears together with the count.
    always_comb begin
        to_hit_s = 1'b0;
        to_idx_s = {IdxWidth{1'b0}};
        for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
            if (((state_d[i] == SLOT_AR) && (32'(cnt_d[i]) >= ArBudget)) ||
                ((state_d[i] == SLOT_R)  && (32'(cnt_d[i]) >= RBudget))) begin
                to_hit_s = 1'b1;
                to_idx_s = IdxWidth'(i);
            end else begin
                to_idx_s = to_idx_s;
            end
        end
        timeout_d      = timeout_q | to_hit_s;
        timeout_slot_d = (!timeout_q && to_hit_s) ? to_idx_s : timeout_slot_q;
    end

    // Timeout flag and latched slot index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q      <= 1'b0;
            timeout_slot_q <= {IdxWidth{1'b0}};
        end else begin
            timeout_q      <= timeout_d;
            timeout_slot_q <= timeout_slot_d;
        end
    end

    assign timeout_o      = timeout_q;
    assign timeout_slot_o = timeout_slot_q;
`else
    assign timeout_o      = 1'b0;
    assign timeout_slot_o = {IdxWidth{1'b0}};
`endif

    // Slot state machines, handshake tracker and flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSlots); i++) begin
                state_q[i] <= SLOT_FREE;
                id_q[i]    <= {IdWidth{1'b0}};
                cnt_q[i]   <= {CntWidth{1'b0}};
            end
            ar_pending_q <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            unexpected_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NumSlots); i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ar_pending_q <= ar_pending_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            unexpected_q <= unexpected_d;
        end
    end

    for (genvar g = 0; g < int'(NumSlots); g++) begin : g_pack
        assign slot_state_o[2*g +: 2]               = state_q[g];
        assign slot_id_o[IdWidth*g +: IdWidth]      = id_q[g];
        assign slot_cnt_o[CntWidth*g +: CntWidth]   = cnt_q[g];
    end

    assign full_o       = full_q;
    assign overflow_o   = overflow_q;
    assign unexpected_o = unexpected_q;

endmodule

// File: tb/tb_rd_slot_ctrl.sv
// Randomized and directed bench for rd_slot_ctrl, checked every cycle against
// a slot-table reference model built directly from the slot rules.
module tb_rd_slot_ctrl;
    localparam int N    = 4;
    localparam int IW   = 4;
    localparam int CW   = 8;
    localparam int AR_B = 16;
    localparam int R_B  = 32;
    localparam int CMAX = (1 << CW) - 1;
`ifdef RD_SLOT_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            ar_valid_i = 1'b0, ar_ready_i = 1'b0, r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
    logic [IW-1:0]   ar_id_i = '0, r_id_i = '0;
    logic [N*2-1:0]  slot_state_o;
    logic [N*IW-1:0] slot_id_o;
    logic [N*CW-1:0] slot_cnt_o;
    logic            full_o, overflow_o, unexpected_o, timeout_o;
    logic [1:0]      timeout_slot_o;

    always #5 clk_i = ~clk_i;

    rd_slot_ctrl #(.NumSlots(N), .IdWidth(IW), .CntWidth(CW), .ArBudget(AR_B), .RBudget(R_B)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
        .slot_state_o(slot_state_o), .slot_id_o(slot_id_o), .slot_cnt_o(slot_cnt_o),
        .full_o(full_o), .overflow_o(overflow_o), .unexpected_o(unexpected_o),
        .timeout_o(timeout_o), .timeout_slot_o(timeout_slot_o)
    );

    // Reference model: 0 FREE, 1 AR_PHASE, 2 R_PHASE
    int m_st[N], m_id[N], m_cnt[N];
    bit m_pend, m_full, m_ovf, m_unx, m_to;
    int m_to_slot;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_id[i] = 0; m_cnt[i] = 0;
        end
        m_pend = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_unx = 1'b0; m_to = 1'b0; m_to_slot = 0;
    endtask

    task automatic model_step(input logic arv, input logic arr, input logic [IW-1:0] arid,
                              input logic rv, input logic rr, input logic rl, input logic [IW-1:0] rid);
        int ns[N];
        int nc[N];
        int fidx, midx, best;
        bit new_ar;
        new_ar = arv && !m_pend;
        fidx = -1;
        for (int i = N - 1; i >= 0; i--) if (m_st[i] == 0) fidx = i;
        midx = -1;
        if (rv && rr) begin
            for (int i = N - 1; i >= 0; i--) if (m_st[i] == 2 && m_id[i] == int'(rid)) midx = i;
            if (midx < 0) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (m_st[i] == 1 && m_id[i] == int'(rid) && m_cnt[i] > best) begin
                        best = m_cnt[i]; midx = i;
                    end
            end
            if (midx < 0) m_unx = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            ns[i] = m_st[i];
            nc[i] = (m_st[i] != 0) ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : 0;
        end
        if (midx >= 0) begin
            if (rl) begin
                ns[midx] = 0; nc[midx] = 0;
            end else if (m_st[midx] == 1) begin
                ns[midx] = 2; nc[midx] = 0;
            end
        end
        if (new_ar) begin
            if (fidx >= 0) begin
                ns[fidx] = 1; nc[fidx] = 0; m_id[fidx] = int'(arid);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_pend = (arv && arr) ? 1'b0 : (new_ar ? 1'b1 : m_pend);
        m_full = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_st[i] = ns[i]; m_cnt[i] = nc[i];
            if (ns[i] == 0) m_full = 1'b0;
        end
        if (TO_EN && !m_to)
            for (int i = N - 1; i >= 0; i--)
                if ((ns[i] == 1 && nc[i] >= AR_B) || (ns[i] == 2 && nc[i] >= R_B)) begin
                    m_to = 1'b1; m_to_slot = i;
                end
    endtask

    task automatic compare_all();
        logic [63:0] es, ei, ec;
        es = '0; ei = '0; ec = '0;
        for (int i = 0; i < N; i++) begin
            es = es | (64'(m_st[i]) << (2 * i));
            ei = ei | (64'(m_id[i]) << (IW * i));
            ec = ec | (64'(m_cnt[i]) << (CW * i));
        end
        check_val("slot_state", 64'(slot_state_o), es);
        check_val("slot_id", 64'(slot_id_o), ei);
        check_val("slot_cnt", 64'(slot_cnt_o), ec);
        check_val("full", 64'(full_o), 64'(m_full));
        check_val("overflow", 64'(overflow_o), 64'(m_ovf));
        check_val("unexpected", 64'(unexpected_o), 64'(m_unx));
        check_val("timeout", 64'(timeout_o), 64'(m_to));
        check_val("timeout_slot", 64'(timeout_slot_o), 64'(m_to_slot));
    endtask

    // Applies one cycle of inputs, advances the model at the edge, checks 1 time unit later.
    task automatic step(input logic arv, input logic arr, input logic [IW-1:0] arid,
                        input logic rv, input logic rr, input logic rl, input logic [IW-1:0] rid);
        ar_valid_i = arv; ar_ready_i = arr; ar_id_i = arid;
        r_valid_i = rv; r_ready_i = rr; r_last_i = rl; r_id_i = rid;
        @(posedge clk_i);
        model_step(arv, arr, arid, rv, rr, rl, rid);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic ar(input logic [IW-1:0] id);
        step(1'b1, 1'b1, id, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic rbeat(input logic [IW-1:0] id, input logic last);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, last, id);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        rst_ni = 1'b0;
        ar_valid_i = 1'b0; ar_ready_i = 1'b0; ar_id_i = '0;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0; r_id_i = '0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic arv, arr, rv, rr, rl;
        logic [IW-1:0] arid, rid;
        int k;

        // Single-beat read
        do_reset();
        ar(4'd3);
        check_val("t1_ar_phase", 64'(slot_state_o[1:0]), 64'd1);
        idle(4);
        check_val("t1_cnt4", 64'(slot_cnt_o[7:0]), 64'd4);
        rbeat(4'd3, 1'b1);
        check_val("t1_free", 64'(slot_state_o), 64'd0);

        // 4-beat burst
        do_reset();
        ar(4'd1);
        idle(3);
        rbeat(4'd1, 1'b0);
        check_val("t2_r_phase", 64'(slot_state_o[1:0]), 64'd2);
        check_val("t2_cnt_restart", 64'(slot_cnt_o[7:0]), 64'd0);
        rbeat(4'd1, 1'b0);
        rbeat(4'd1, 1'b0);
        rbeat(4'd1, 1'b1);
        check_val("t2_free", 64'(slot_state_o[1:0]), 64'd0);

        // Same ID twice: oldest matches
        do_reset();
        ar(4'd2);
        ar(4'd2);
        idle(1);
        rbeat(4'd2, 1'b1);
        check_val("t3_oldest", 64'(slot_state_o[3:0]), 64'h4);

        // Fill, overflow, free and reuse
        do_reset();
        for (int i = 0; i < 4; i++) ar(4'(i));
        check_val("t4_full", 64'(full_o), 64'd1);
        check_val("t4_no_ovf", 64'(overflow_o), 64'd0);
        ar(4'd4);
        check_val("t4_ovf", 64'(overflow_o), 64'd1);
        rbeat(4'd0, 1'b1);
        check_val("t4_not_full", 64'(full_o), 64'd0);
        ar(4'd9);
        check_val("t4_realloc_id", 64'(slot_id_o[3:0]), 64'd9);
        check_val("t4_realloc_st", 64'(slot_state_o[1:0]), 64'd1);

        // Stray R beat
        do_reset();
        rbeat(4'd7, 1'b1);
        check_val("t5_unexpected", 64'(unexpected_o), 64'd1);
        check_val("t5_states", 64'(slot_state_o), 64'd0);

        // AR budget
        do_reset();
        ar(4'd0);
        idle(15);
        check_val("t6_before_budget", 64'(timeout_o), 64'd0);
        idle(1);
        check_val("t6_at_budget", 64'(timeout_o), 64'(TO_EN));
        check_val("t6_slot", 64'(timeout_slot_o), 64'd0);
        idle(300);

        // Reset in the middle of traffic
        ar(4'd5);
        rbeat(4'd5, 1'b0);
        do_reset();
        check_val("t7_all_free", 64'(slot_state_o), 64'd0);

        // Randomized traffic, three segments with different densities
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            arv = 1'b0; arid = '0;
            for (int c = 0; c < 700; c++) begin
                if (!arv || ar_ready_i) begin
                    arv  = ($urandom_range(0, 9) < 3 + seg);
                    arid = 4'($urandom_range(0, 3));
                end
                arr = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 9) < 4 + seg);
                rr  = ($urandom_range(0, 4) != 0);
                rl  = ($urandom_range(0, 2) != 0);
                k   = int'($urandom_range(0, N - 1));
                if (m_st[k] != 0 && $urandom_range(0, 7) != 0) rid = 4'(m_id[k]);
                else rid = 4'($urandom_range(0, 7));
                step(arv, arr, arid, rv, rr, rl, rid);
                if (seg == 1 && c == 350) begin
                    do_reset();
                    arv = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
